// File: rtl/masked_inv_sbox_layer_serial_if.sv
// Handshake and share bus for the serial masked inverse S-box layer.
// The controller drives start, the input shares and fresh randomness; the layer returns status and output shares.
interface masked_inv_sbox_layer_serial_if #(
    parameter int RW = 8
);
    logic          start;
    logic [63:0]   in_s1;
    logic [63:0]   in_s2;
    logic [63:0]   in_s3;
    logic [RW-1:0] rnd;
    logic          busy;
    logic          done;
    logic [63:0]   out_s1;
    logic [63:0]   out_s2;
    logic [63:0]   out_s3;

    modport master (
        output start, in_s1, in_s2, in_s3, rnd,
        input  busy, done, out_s1, out_s2, out_s3
    );

    modport slave (
        input  start, in_s1, in_s2, in_s3, rnd,
        output busy, done, out_s1, out_s2, out_s3
    );
endinterface

// File: rtl/masked_inv_sbox_layer_serial.sv
// Three-share masked inverse PRESENT/LED S-box layer, one nibble per cycle through a
// 3-stage non-complete pipeline: quadratic terms, then cubic terms, then share-local recombination.
module masked_inv_sbox_layer_serial #(
    parameter int RW = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    masked_inv_sbox_layer_serial_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic busy_c, done_c, load_en, feed_en;

    logic [RW-1:0] rnd_w;
    assign rnd_w = bus.rnd;

    // Share vectors are 3 bits wide: bit 0 = share 1, bit 1 = share 2, bit 2 = share 3.
    // Output share j of a product never touches input share j.
    function automatic logic [2:0] ti_and(input logic [2:0] x, input logic [2:0] y);
        ti_and = {x[0] & y[0] ^ x[0] & y[1] ^ x[1] & y[0],
                  x[2] & y[2] ^ x[2] & y[0] ^ x[0] & y[2],
                  x[1] & y[1] ^ x[1] & y[2] ^ x[2] & y[1]};
    endfunction

    function automatic logic [2:0] ti_lin(input logic [2:0] x);
        ti_lin = {x[0], x[2], x[1]};
    endfunction

    // Two random bits whose three-way XOR cancels, so the unmasked value is untouched.
    function automatic logic [2:0] refresh(input logic [2:0] z, input logic [1:0] r);
        refresh = z ^ {r[0] ^ r[1], r[1], r[0]};
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_FEED;
                    cnt_next   = 4'd0;
                end
            end
            S_FEED: begin
                if (cnt_reg == 4'd15) begin
                    state_next = S_DRAIN;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_reg == 4'd2) begin
                    state_next = S_DONE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c  = 1'b0;
        done_c  = 1'b0;
        load_en = 1'b0;
        feed_en = 1'b0;
        case (state_reg)
            S_IDLE:  load_en = bus.start;
            S_FEED:  begin busy_c = 1'b1; feed_en = 1'b1; end
            S_DRAIN: busy_c = 1'b1;
            S_DONE:  done_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;

    // ---------------- per-share shift registers ----------------
    logic [2:0][63:0] in_bus;
    logic [2:0][63:0] out_bus;
    logic [2:0]       a_v, b_v, c_v, d_v;
    logic [3:0][2:0]  q1_reg, q2_reg;
    logic [2:0]       pab_reg, pac_reg, c_reg, d_reg, u_reg, v_reg;
    logic             v1_reg, v2_reg;

    assign in_bus = {bus.in_s3, bus.in_s2, bus.in_s1};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_share
            logic [63:0] in_sh_reg;
            logic [63:0] out_sh_reg;
            logic [3:0]  out_nib;
            // The S-box constant is folded into share 1 only.
            localparam logic ONE_C = (gi == 0) ? 1'b1 : 1'b0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    in_sh_reg <= 64'd0;
                end else if (load_en) begin
                    in_sh_reg <= in_bus[gi];
                end else if (feed_en) begin
                    in_sh_reg <= {4'h0, in_sh_reg[63:4]};
                end
            end

            assign a_v[gi] = in_sh_reg[0];
            assign b_v[gi] = in_sh_reg[1];
            assign c_v[gi] = in_sh_reg[2];
            assign d_v[gi] = in_sh_reg[3];

            // Stage 3: each output share uses only its own share index.
            assign out_nib = {q2_reg[3][gi] ^ u_reg[gi],
                              q2_reg[2][gi] ^ u_reg[gi] ^ v_reg[gi] ^ ONE_C,
                              q2_reg[1][gi] ^ u_reg[gi] ^ v_reg[gi],
                              q2_reg[0][gi] ^ ONE_C};

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_sh_reg <= 64'd0;
                end else if (v2_reg) begin
                    out_sh_reg <= {out_nib, out_sh_reg[63:4]};
                end
            end

            assign out_bus[gi] = out_sh_reg;
        end
    endgenerate

    assign bus.out_s1 = out_bus[0];
    assign bus.out_s2 = out_bus[1];
    assign bus.out_s3 = out_bus[2];

    // ---------------- stage 1: linear + quadratic part of invS ----------------
    // invS ANF (a=bit0 .. d=bit3), constants added in stage 3:
    //   y0 = a^c^bd                    y1 = a^b^d^ac^bd^cd  ^ abc^abd^acd
    //   y2 = d^ab^ac^bc^ad^bd ^ abc^abd^acd    y3 = a^b^c^d^ab ^ abc^acd
    logic [2:0] y0_s, y1_s, y2_s, y3_s, ab_s, ac_s;

    assign ab_s = ti_and(a_v, b_v);
    assign ac_s = ti_and(a_v, c_v);
    assign y0_s = ti_lin(a_v) ^ ti_lin(c_v) ^ ti_and(b_v, d_v);
    assign y1_s = ti_lin(a_v) ^ ti_lin(b_v) ^ ti_lin(d_v) ^ ac_s
                ^ ti_and(b_v, d_v) ^ ti_and(c_v, d_v);
    assign y2_s = ti_lin(d_v) ^ ab_s ^ ac_s ^ ti_and(b_v, c_v)
                ^ ti_and(a_v, d_v) ^ ti_and(b_v, d_v);
    assign y3_s = ti_lin(a_v) ^ ti_lin(b_v) ^ ti_lin(c_v) ^ ti_lin(d_v) ^ ab_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg  <= 1'b0;
            q1_reg  <= '0;
            pab_reg <= 3'd0;
            pac_reg <= 3'd0;
            c_reg   <= 3'd0;
            d_reg   <= 3'd0;
        end else begin
            v1_reg <= feed_en;
            if (feed_en) begin
                q1_reg  <= {y3_s, y2_s, y1_s, y0_s};
                pab_reg <= refresh(ab_s, rnd_w[1:0]);
                pac_reg <= refresh(ac_s, rnd_w[3:2]);
                c_reg   <= c_v;
                d_reg   <= d_v;
            end
        end
    end

    // ---------------- stage 2: cubic terms U = abc^acd, V = abd ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg <= 1'b0;
            q2_reg <= '0;
            u_reg  <= 3'd0;
            v_reg  <= 3'd0;
        end else begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                q2_reg <= q1_reg;
                u_reg  <= refresh(ti_and(pab_reg, c_reg) ^ ti_and(pac_reg, d_reg), rnd_w[5:4]);
                v_reg  <= refresh(ti_and(pab_reg, d_reg), rnd_w[7:6]);
            end
        end
    end
endmodule

// File: tb/tb_masked_inv_sbox_layer_serial.sv
// Self-checking bench for the masked inverse S-box layer: directed vectors plus a
// randomly shared regression compared against a table-based invS reference.
module tb_masked_inv_sbox_layer_serial;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    masked_inv_sbox_layer_serial_if #(.RW(8)) bus ();

    masked_inv_sbox_layer_serial #(.RW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] inv_tbl [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                 4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    function automatic logic [63:0] ref_inv(input logic [63:0] x);
        logic [63:0] r;
        r = 64'd0;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_tbl[x[4*n +: 4]];
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] out_xor();
        return bus.out_s1 ^ bus.out_s2 ^ bus.out_s3;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Fresh randomness every cycle, changed away from the active edge.
    initial begin
        bus.rnd = 8'd0;
        forever begin
            @(negedge clk);
            bus.rnd = 8'($urandom);
        end
    end

    // One operation starting at the next edge; optional spurious start at cycle t+extra_at.
    task automatic run_op(input string tag, input logic [63:0] s1, input logic [63:0] s2,
                          input logic [63:0] s3, input int extra_at, input logic [63:0] exp);
        int lat;
        int busy_bad;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.in_s1 = s1; bus.in_s2 = s2; bus.in_s3 = s3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy !== 1'b1) busy_bad++;
            if (lat == extra_at) begin
                bus.start = 1'b1;
                bus.in_s1 = ~s1;
            end else if (lat == extra_at + 1) begin
                bus.start = 1'b0;
                bus.in_s1 = s1;
            end
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd20);
        check_eq({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        check_eq({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "_xor"}, out_xor(), exp);
        $display("[%s] in=%h lat=%0d out=%h exp=%h", tag, s1 ^ s2 ^ s3, lat, out_xor(), exp);
    endtask

    initial begin
        logic [63:0] x, s2, s3;
        int pulses;

        // Reset held two cycles with start asserted alongside it.
        rst = 1'b1;
        bus.start = 1'b1;
        bus.in_s1 = 64'h0123456789ABCDEF; bus.in_s2 = 64'd0; bus.in_s3 = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_out1", bus.out_s1, 64'd0);
        check_eq("rst_out2", bus.out_s2, 64'd0);
        check_eq("rst_out3", bus.out_s3, 64'd0);
        rst = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_start_ignored", 64'(bus.busy), 64'd0);
        $display("[reset] busy=%0d done=%0d", bus.busy, bus.done);

        // Unshared directed vectors.
        run_op("unshared", 64'h0123456789ABCDEF, 64'd0, 64'd0, -1, 64'h5EF8C12DB463079A);
        run_op("ascend",   64'hFEDCBA9876543210, 64'd0, 64'd0, -1, 64'hA970364BD21C8FE5);

        // Same secret under two independent sharings and randomness streams.
        for (int k = 0; k < 2; k++) begin
            s2 = rand64(); s3 = rand64();
            run_op("share_cc", 64'hCCCCCCCCCCCCCCCC ^ s2 ^ s3, s2, s3, -1, 64'd0);
        end

        // Spurious start at t+5 must not disturb the running operation.
        s2 = rand64(); s3 = rand64();
        run_op("start_busy", 64'h0123456789ABCDEF ^ s2 ^ s3, s2, s3, 5, 64'h5EF8C12DB463079A);
        @(posedge clk); #1;
        check_eq("start_busy_single_done", 64'(bus.done), 64'd0);
        check_eq("start_busy_idle", 64'(bus.busy), 64'd0);
        check_eq("start_busy_hold", out_xor(), 64'h5EF8C12DB463079A);

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.in_s1 = 64'hFEDCBA9876543210; bus.in_s2 = 64'd0; bus.in_s3 = 64'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_busy", 64'(bus.busy), 64'd0);
        check_eq("midrst_out1", bus.out_s1, 64'd0);
        check_eq("midrst_out2", bus.out_s2, 64'd0);
        check_eq("midrst_out3", bus.out_s3, 64'd0);
        pulses = 0;
        repeat (30) begin
            if (bus.done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        check_eq("midrst_no_done", 64'(pulses), 64'd0);
        $display("[midrst] busy=%0d done_pulses=%0d", bus.busy, pulses);
        run_op("after_rst", 64'h0123456789ABCDEF, 64'd0, 64'd0, -1, 64'h5EF8C12DB463079A);

        // Back-to-back random regression at the earliest legal start edge.
        for (int k = 0; k < 1000; k++) begin
            x = rand64(); s2 = rand64(); s3 = rand64();
            run_op("regr", x ^ s2 ^ s3, s2, s3, -1, ref_inv(x));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule
